// File: rtl/tmr_mac_accumulator.sv
// rtl/tmr_mac_accumulator.sv - sequential saturating MAC controller behind a TMR multiplier
module tmr_mac_accumulator #(
    parameter int N         = 16,
    parameter int INTBITS   = 6,
    parameter int FRACBITS  = 10,
    parameter int CNTW      = 8,
    parameter int MAX_RETRY = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [CNTW-1:0] num_inputs,
    input  logic [N-1:0]    bias,
    input  logic            in_valid,
    input  logic [N-1:0]    in_x,
    input  logic [N-1:0]    in_w,
    output logic            in_ready,
    output logic [N-1:0]    mul_a,
    output logic [N-1:0]    mul_b,
    input  logic [N-1:0]    mul_result,
    input  logic            mul_invalid,
    input  logic            mul_ovf,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_sum,
    output logic            out_ovf,
    output logic            out_fault,
    output logic            busy
);

    // Retry counter must hold values 0..MAX_RETRY; keep at least one bit.
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_EVAL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [N-1:0]    acc;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] num_lat;
    logic [RW-1:0]   retry;

    logic [N:0]      sum_ext;
    logic            sat_hi;
    logic            sat_lo;
    logic [N-1:0]    acc_sat;
    logic            retry_again;
    logic            last_pair;

    // Saturating accumulate: one extra bit detects two's-complement overflow.
    always_comb begin
        sum_ext = {acc[N-1], acc} + {mul_result[N-1], mul_result};
        sat_hi  = ~sum_ext[N] &  sum_ext[N-1];
        sat_lo  =  sum_ext[N] & ~sum_ext[N-1];
        acc_sat = sum_ext[N-1:0];
        if (sat_hi) begin
            acc_sat = {1'b0, {(N-1){1'b1}}};
        end else if (sat_lo) begin
            acc_sat = {1'b1, {(N-1){1'b0}}};
        end
    end

    assign retry_again = mul_invalid && (retry < RW'(MAX_RETRY));
    assign last_pair   = ((cnt + CNTW'(1)) == num_lat);
    assign out_sum     = acc;

    // State register; reset aborts any accumulation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs, decoded straight from the state.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (num_inputs == '0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = S_EVAL;
                end
            end
            S_EVAL: begin
                if (!retry_again) begin
                    state_nxt = last_pair ? S_DONE : S_WAIT;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, retry bookkeeping, accumulation and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            num_lat   <= '0;
            retry     <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            out_ovf   <= 1'b0;
            out_fault <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        num_lat   <= num_inputs;
                        acc       <= bias;
                        cnt       <= '0;
                        retry     <= '0;
                        out_ovf   <= 1'b0;
                        out_fault <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (in_valid) begin
                        mul_a <= in_x;
                        mul_b <= in_w;
                        retry <= '0;
                    end
                end
                S_EVAL: begin
                    if (retry_again) begin
                        retry <= retry + RW'(1);
                    end else begin
                        // Retries exhausted still accumulate the best-effort product.
                        acc <= acc_sat;
                        cnt <= cnt + CNTW'(1);
                        if (sat_hi || sat_lo || mul_ovf) begin
                            out_ovf <= 1'b1;
                        end
                        if (mul_invalid) begin
                            out_fault <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/tmr_mac_accumulator.md
Name: tmr_mac_accumulator

Overview:
- Sequential multiply-accumulate controller for one fault-tolerant neuron; sits directly downstream of the TMR multiplier.
- Accepts input/weight pairs over a valid/ready handshake and drives the multiplier operands from registers.
- Samples the voted product, the invalid (no-majority) flag and the overflow flag; retries a product flagged invalid.
- Accumulates the products onto a bias with saturation and presents the neuron pre-activation sum over a valid/ready output.

Parameters:
- N, 16, total word width, signed fixed point.
- INTBITS, 6, integer bits including sign.
- FRACBITS, 10, fraction bits; INTBITS+FRACBITS must equal N.
- CNTW, 8, width of the input-count field.
- MAX_RETRY, 2, number of re-samples allowed per product while the invalid flag is asserted.

Ports:
- clk  in  1  clock, all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begins an accumulation; ignored unless the block is in IDLE.
- num_inputs  in  CNTW  number of pairs to consume, latched on start.
- bias  in  N  initial accumulator value, latched on start.
- in_valid  in  1  upstream pair valid.
- in_x  in  N  neuron input.
- in_w  in  N  weight.
- in_ready  out  1  high only in WAIT.
- mul_a  out  N  registered operand A to the multiplier.
- mul_b  out  N  registered operand B to the multiplier.
- mul_result  in  N  voted product.
- mul_invalid  in  1  no-majority flag from the multiplier.
- mul_ovf  in  1  product overflow flag.
- out_valid  out  1  high in DONE.
- out_ready  in  1  downstream accept.
- out_sum  out  N  accumulated sum.
- out_ovf  out  1  sticky: product overflow or accumulator saturation occurred.
- out_fault  out  1  sticky: retries were exhausted on at least one product.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs, the accumulator, the counters and the sticky flags are 0; the state is IDLE.
- States are IDLE, WAIT, EVAL and DONE.
- IDLE, on start:
  - Latch num_inputs. Set acc=bias and cnt=0. Clear retry, out_ovf and out_fault.
  - If num_inputs==0, go to DONE with out_sum=bias; otherwise go to WAIT.
- WAIT:
  - in_ready=1.
  - When in_valid && in_ready: register mul_a=in_x, mul_b=in_w, set retry=0, go to EVAL.
  - No other pair is accepted until the block returns to WAIT.
- EVAL (multiplier is combinational; its output is sampled one cycle after the operands are registered):
  - If mul_invalid && retry<MAX_RETRY: retry++, stay in EVAL, hold the operands. No accumulation.
  - Otherwise, accumulate mul_result:
    - Compute the sum as an N+1-bit signed add.
    - If the sum exceeds 2^(N-1)-1, clamp to 0x7FFF (N=16). If it is below -2^(N-1), clamp to 0x8000.
    - Set out_ovf on clamp or when mul_ovf=1.
    - If mul_invalid is still 1 at this point, set out_fault and accumulate mul_result anyway.
    - cnt++. If cnt+1==num_inputs, go to DONE; otherwise go to WAIT.
- DONE:
  - out_valid=1 and out_sum=acc, both held stable until out_ready.
  - On out_valid && out_ready, go to IDLE; out_valid falls in the next cycle.
- busy=1 in WAIT, EVAL and DONE.
- start outside IDLE is ignored. num_inputs and bias changes after the start cycle have no effect.
- Best-case latency per pair is 2 cycles (WAIT handshake, then EVAL); each retry adds 1 cycle.
- Asynchronous reset mid-operation aborts immediately: in_ready and out_valid drop without waiting for a clock, and the partial sum is discarded.
- Sticky flags clear only on reset or on the next accepted start.

Test Plan:
- start, bias=0x0400 (1.0), num_inputs=2, pairs (0x0800,0x0C00) and (0x0400,0x0400), no faults:
  - out_sum=0x2000 (8.0), out_ovf=0, out_fault=0.
  - out_valid asserts 5 cycles after the start cycle when in_valid is held high.
- Same run with mul_invalid forced high for one EVAL cycle on the first pair:
  - One extra cycle; out_sum=0x2000, out_fault=0.
- mul_invalid held high through 3 EVAL cycles (MAX_RETRY=2) on a pair:
  - Product accumulated after 2 retries; out_fault=1.
- bias=0x7C00, product 0x0800 (+2.0) with mul_ovf=0:
  - out_sum clamps to 0x7FFF, out_ovf=1.
  - Repeat with a negative bias and a negative product and require 0x8000.
- num_inputs=0, bias=0xFC00:
  - DONE the cycle after start, out_sum=0xFC00, in_ready never asserts.
  - out_ready held low for 4 cycles: out_valid and out_sum stay stable.
- rst_n pulled low while in EVAL:
  - busy, in_ready and out_valid fall immediately and the block returns to IDLE.
  - A following start gives a clean result with no leftover sum or flags.
